uart_tx: RTL and testbench
==========================

# uart_tx

Asynchronous serial transmitter, 8N1, LSB first; the sending stage paired with the team's UART receiver. Accepts bytes on the same single-cycle strobe interface that the receiver produces (`po_data`/`po_flag`), so an rx→tx loopback is a direct wire-up. A small input FIFO absorbs back-to-back strobes while a frame is on the line. A serializer FSM drives the `tx` pin at the configured baud.

## Interface
- `CNT_BAUD_MAX`, 5207: clocks per bit minus 1 (50 MHz / 9600 baud).
- `FIFO_DEPTH`, 4: input buffer entries; must be a power of 2, ≥2.
- `FIFO_AW`, 2: log2(`FIFO_DEPTH`).

- `sclk` in 1: system clock; single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `pi_data` in 8: byte to send; sampled only when `pi_flag`=1.
- `pi_flag` in 1: one-cycle write strobe.
- `tx` out 1: serial line; idles high.
- `tx_busy` out 1: 1 while the FIFO is non-empty or the FSM is not in IDLE.
- `fifo_full` out 1: 1 when the FIFO holds `FIFO_DEPTH` bytes.
- `drop_flag` out 1: one-cycle pulse when a strobe is rejected because the FIFO is full.

## Operation
- Reset values: `tx`=1, `tx_busy`=0, `fifo_full`=0, `drop_flag`=0. FIFO pointers, count, FSM state, baud counter and bit counter all clear to 0 / IDLE.
- Write: on `pi_flag`=1 with count < `FIFO_DEPTH`, push `pi_data`. Otherwise discard the byte and assert `drop_flag` on the next cycle.
- Full is judged on the count registered at the start of the cycle. A pop in the same cycle does not free a slot for a write in that cycle.
- Simultaneous push and pop when not full: count is unchanged and both pointers advance.
- FSM states and transitions:
  - IDLE: `tx`=1. If the FIFO is not empty, pop into the 8-bit shift register and go to START.
  - START: `tx`=0 for one bit period, then go to DATA.
  - DATA: drive `shift[0]` for one bit period, then shift right. After the bit counter reaches 7, go to STOP.
  - STOP: `tx`=1 for one bit period, then go to IDLE.
- Bit period is `CNT_BAUD_MAX`+1 clocks. The baud counter runs only outside IDLE. It wraps to 0 at `CNT_BAUD_MAX`, and that wrap cycle is the bit-end event.
- Bit counter is 3 bits. It increments at each DATA bit-end and clears on leaving DATA.
- Pointers are `FIFO_AW` bits and wrap naturally. Count is `FIFO_AW`+1 bits.
- `tx` is a registered output; it must be glitch-free.
- Reset asserted mid-frame: `tx` returns to 1 immediately (asynchronous). Queued bytes are lost. The next frame begins only after a new strobe.

## Timing
- Strobe in cycle 0 into an empty FIFO with the FSM idle:
  - cycle 1: byte visible in the FIFO, `tx_busy`=1.
  - cycle 2 (clock edge ending cycle 1): pop happens and `tx` falls.
- `tx` falls exactly 2 clocks after the strobe cycle.
- Frame length is 10×(`CNT_BAUD_MAX`+1) clocks.
- Back-to-back queued frames are separated by exactly 1 idle clock of `tx`=1 beyond the stop bit.
- `tx_busy` falls on the clock after STOP ends if the FIFO is empty.
- `fifo_full` and `drop_flag` are registered and change only on clock edges.

## Structure
- Shared UART package/header (also used by the receiver): default `CNT_BAUD_MAX`, its half-bit value, and data width 8.
- FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3) are local to `uart_tx`.
- One sub-module, `uart_tx_fifo`: synchronous FIFO with ports wr_en/wr_data/rd_en/rd_data/empty/full/count, parameterized by `FIFO_DEPTH`/`FIFO_AW`.
- The FSM, baud counter and shift register live in the top module.

## Test plan
All scenarios use `CNT_BAUD_MAX`=9 (10 clocks per bit).
- Single byte 0x55:
  - `tx` falls 2 clocks after the strobe.
  - Line then reads 0,1,0,1,0,1,0,1,0,1 with each level held 10 clocks.
  - `tx_busy` is 1 for exactly 101 clocks.
- Strobes of 0xA5, 0x3C on consecutive cycles:
  - both frames are sent in order;
  - the gap between the stop bit of frame 1 and the start bit of frame 2 is 1 clock;
  - no `drop_flag`.
- Six strobes 0x01..0x06 on consecutive cycles with `FIFO_DEPTH`=4:
  - `fifo_full` rises;
  - `drop_flag` pulses for each rejected byte;
  - only the bytes that were accepted are transmitted, in strobe order.
- Strobe while full, in the same cycle as a pop: byte is dropped, `drop_flag`=1 for one clock, count unchanged.
- `rst_n` pulsed low during DATA bit 3 of 0xFF:
  - `tx`=1 and `tx_busy`=0 immediately;
  - no further frame appears;
  - a subsequent strobe of 0x00 is sent correctly.
- Loopback: the transmitter's `tx` drives the receiver's `rx`, and the receiver's `po_data`/`po_flag` drive `pi_data`/`pi_flag`. Bytes 0x00, 0xFF, 0x5A injected on the receiver's line reappear bit-exact on `tx`.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
// Holds the default baud divisor, the data width and small sizing helpers.
package uart_tx_pkg;

    localparam int CNT_BAUD_MAX_DEF = 5207;  // 50 MHz / 9600 baud, minus 1
    localparam int DATA_W           = 8;

    typedef logic [DATA_W-1:0] uart_byte_t;

    // Mid-bit sample point, used by the receiver to centre its sampling.
    function automatic int half_bit(input int cnt_max);
        return (cnt_max + 1) / 2;
    endfunction

    // Width of a counter that must hold 0..cnt_max.
    function automatic int cnt_width(input int cnt_max);
        return (cnt_max > 0) ? $clog2(cnt_max + 1) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO buffering strobed bytes ahead of the serializer.
// Full is judged on the registered count, so a same-cycle pop never frees a slot for a write.
module uart_tx_fifo
    import uart_tx_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int FIFO_AW    = 2
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [FIFO_AW:0]  count
);

    localparam logic [FIFO_AW:0] DEPTH_C = (FIFO_AW + 1)'(FIFO_DEPTH);

    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count_next;
    logic               push;
    logic               pop;

    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !push) begin
            count_next = count - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
            full  <= (count_next == DEPTH_C);
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and count alone define validity.
    always_ff @(posedge sclk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first, fed by the receiver-style po_data/po_flag strobe.
// Input FIFO absorbs bursts; a four-state serializer drives a registered tx line.
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int CNT_BAUD_MAX = CNT_BAUD_MAX_DEF,
    parameter int FIFO_DEPTH   = 4,
    parameter int FIFO_AW      = 2
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] pi_data,
    input  logic              pi_flag,
    output logic              tx,
    output logic              tx_busy,
    output logic              fifo_full,
    output logic              drop_flag
);

    localparam int              BAUD_W   = cnt_width(CNT_BAUD_MAX);
    localparam logic [BAUD_W-1:0] BAUD_END = BAUD_W'(CNT_BAUD_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    tx_state_t          state, state_next;
    logic [BAUD_W-1:0]  baud_cnt;
    logic [2:0]         bit_cnt, bit_cnt_next;
    logic [DATA_W-1:0]  shift, shift_next;
    logic               tx_next;
    logic               bit_end;
    logic               rd_en;
    logic               fifo_empty;
    logic [DATA_W-1:0]  fifo_rd_data;
    logic [FIFO_AW:0]   fifo_count;

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .FIFO_AW    (FIFO_AW)
    ) u_fifo (
        .sclk    (sclk),
        .rst_n   (rst_n),
        .wr_en   (pi_flag),
        .wr_data (pi_data),
        .rd_en   (rd_en),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    assign bit_end = (state != IDLE) && (baud_cnt == BAUD_END);
    assign tx_busy = (fifo_count != '0) || (state != IDLE);

    // tx_next is the line level for the state being entered, keeping tx a clean flop output.
    always_comb begin
        state_next   = state;
        shift_next   = shift;
        bit_cnt_next = bit_cnt;
        tx_next      = tx;
        rd_en        = 1'b0;
        case (state)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty) begin
                    rd_en      = 1'b1;
                    shift_next = fifo_rd_data;
                    state_next = START;
                    tx_next    = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next = DATA;
                    tx_next    = shift[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shift_next = shift >> 1;
                    if (bit_cnt == 3'd7) begin
                        state_next   = STOP;
                        bit_cnt_next = 3'd0;
                        tx_next      = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt + 3'd1;
                        tx_next      = shift[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    state_next = IDLE;
                    tx_next    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_cnt   <= 3'd0;
            shift     <= '0;
            tx        <= 1'b1;
            drop_flag <= 1'b0;
        end else begin
            state     <= state_next;
            bit_cnt   <= bit_cnt_next;
            shift     <= shift_next;
            tx        <= tx_next;
            drop_flag <= pi_flag && fifo_full;
            if (state == IDLE || bit_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomized bench for uart_tx: a line trace is decoded into frames and
// compared with a transaction-level model of buffer occupancy and frame timing.
module tb_uart_tx;

    localparam int CNT_BAUD_MAX = 9;
    localparam int FIFO_DEPTH   = 4;
    localparam int FIFO_AW      = 2;
    localparam int BIT_CLKS     = CNT_BAUD_MAX + 1;
    localparam int FRAME_CLKS   = 10 * BIT_CLKS;

    logic       sclk    = 1'b0;
    logic       rst_n   = 1'b0;
    logic [7:0] pi_data = 8'h00;
    logic       pi_flag = 1'b0;
    logic       tx;
    logic       tx_busy;
    logic       fifo_full;
    logic       drop_flag;
    logic       rx_line = 1'b1;

    int checks = 0;
    int errors = 0;

    // Model: bytes waiting in the buffer, clocks left in the frame on the line, expected byte stream.
    int         occ;
    int         busy_left;
    int         drops_exp;
    int         drops_act;
    int         busy_cycles;
    logic       full_seen;
    logic [7:0] exp_q[$];
    logic       trace[$];
    int         fr_start[$];
    logic [7:0] fr_data[$];
    logic       fr_ok[$];

    always #5 sclk = ~sclk;

    uart_tx #(
        .CNT_BAUD_MAX (CNT_BAUD_MAX),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .FIFO_AW      (FIFO_AW)
    ) dut (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .pi_data   (pi_data),
        .pi_flag   (pi_flag),
        .tx        (tx),
        .tx_busy   (tx_busy),
        .fifo_full (fifo_full),
        .drop_flag (drop_flag)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        occ = 0;
        busy_left = 0;
        drops_exp = 0;
        drops_act = 0;
        busy_cycles = 0;
        full_seen = 1'b0;
        exp_q.delete();
    endtask

    // One clock: drive the strobe, advance the model across the edge, sample #1 later.
    task automatic tick(input logic f, input logic [7:0] d);
        logic full_s;
        logic pop_s;
        logic drop_e;
        pi_flag = f;
        pi_data = d;
        @(posedge sclk);
        full_s = (occ == FIFO_DEPTH);
        pop_s  = (busy_left == 0) && (occ > 0);
        drop_e = f && full_s;
        if (f && !full_s) begin
            occ++;
            exp_q.push_back(d);
        end
        if (pop_s) begin
            occ--;
            busy_left = FRAME_CLKS;
        end else if (busy_left > 0) begin
            busy_left--;
        end
        if (drop_e) drops_exp++;
        #1;
        pi_flag = 1'b0;
        check("drop_flag", drop_flag, drop_e);
        check("fifo_full", fifo_full, occ == FIFO_DEPTH);
        check("tx_busy", tx_busy, (occ > 0) || (busy_left > 0));
        trace.push_back(tx);
        if (tx_busy === 1'b1) busy_cycles++;
        if (drop_flag === 1'b1) drops_act++;
        if (fifo_full === 1'b1) full_seen = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick(1'b0, 8'h00);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((occ > 0 || busy_left > 0) && guard < 2000) begin
            tick(1'b0, 8'h00);
            guard++;
        end
        check("drain_bound", guard < 2000, 1'b1);
        idle(3);
    endtask

    // Cut the sampled line into frames: each low after idle opens a 10-bit frame.
    task automatic decode();
        int         i;
        logic       ok;
        logic [7:0] d;
        fr_start.delete();
        fr_data.delete();
        fr_ok.delete();
        i = 0;
        while (i < trace.size()) begin
            if (trace[i] === 1'b0) begin
                ok = 1'b1;
                d  = 8'h00;
                if (i + FRAME_CLKS > trace.size()) begin
                    ok = 1'b0;
                end else begin
                    for (int b = 0; b < 10; b++) begin
                        for (int j = 1; j < BIT_CLKS; j++) begin
                            if (trace[i + b*BIT_CLKS + j] !== trace[i + b*BIT_CLKS]) ok = 1'b0;
                        end
                        if (b >= 1 && b <= 8) d[b-1] = trace[i + b*BIT_CLKS];
                    end
                    if (trace[i + 9*BIT_CLKS] !== 1'b1) ok = 1'b0;
                end
                fr_start.push_back(i);
                fr_data.push_back(d);
                fr_ok.push_back(ok);
                i += FRAME_CLKS;
            end else begin
                i++;
            end
        end
    endtask

    task automatic check_frames(input string tag);
        int n_exp;
        decode();
        n_exp = exp_q.size();
        check({tag, "_frame_count"}, fr_start.size(), n_exp);
        for (int k = 0; k < fr_start.size(); k++) begin
            check($sformatf("%s_shape%0d", tag, k), fr_ok[k], 1'b1);
            if (exp_q.size() > 0) check($sformatf("%s_byte%0d", tag, k), fr_data[k], exp_q.pop_front());
        end
        exp_q.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] bits;
        logic [7:0] rec;
        logic [7:0] lb_bytes [3];
        int         guard;

        // Reset state
        repeat (3) @(posedge sclk);
        #1;
        check("rst_tx", tx, 1'b1);
        check("rst_busy", tx_busy, 1'b0);
        check("rst_full", fifo_full, 1'b0);
        check("rst_drop", drop_flag, 1'b0);
        rst_n = 1'b1;
        model_reset();
        idle(5);

        // Single byte 0x55: fall 2 clocks after the strobe, busy for one frame plus one clock
        trace.delete();
        busy_cycles = 0;
        tick(1'b1, 8'h55);
        drain();
        idle(5);
        check_frames("s1");
        if (fr_start.size() > 0) check("s1_fall_latency", fr_start[0] + 1, 2);
        check("s1_busy_clocks", busy_cycles, FRAME_CLKS + 1);

        // Back-to-back 0xA5, 0x3C: one idle clock between frames, nothing dropped
        trace.delete();
        drops_exp = 0;
        drops_act = 0;
        tick(1'b1, 8'hA5);
        tick(1'b1, 8'h3C);
        drain();
        check("s2_drops", drops_act, drops_exp);
        check_frames("s2");
        if (fr_start.size() > 1) check("s2_gap", fr_start[1] - fr_start[0] - FRAME_CLKS, 1);

        // Overflow burst 0x01..0x06
        trace.delete();
        drops_exp = 0;
        drops_act = 0;
        full_seen = 1'b0;
        for (int i = 1; i <= 6; i++) tick(1'b1, 8'(i));
        drain();
        check("s3_full_seen", full_seen, 1'b1);
        check("s3_drops", drops_act, drops_exp);
        check("s3_one_drop", drops_act, 1);
        check_frames("s3");

        // Random burst to fill the buffer, then a strobe landing on the pop edge
        trace.delete();
        drops_exp = 0;
        drops_act = 0;
        for (int i = 0; i < 5; i++) tick(1'b1, 8'($urandom));
        guard = 0;
        while (busy_left != 0 && guard < 300) begin
            tick(1'b0, 8'h00);
            guard++;
        end
        tick(1'b1, 8'($urandom));
        check("s4_drop_on_pop", drop_flag, 1'b1);
        check("s4_count", dut.u_fifo.count, FIFO_DEPTH - 1);
        tick(1'b0, 8'h00);
        check("s4_drop_one_clock", drop_flag, 1'b0);
        drain();
        check("s4_drops", drops_act, drops_exp);
        check_frames("s4");

        // Reset during data bit 3 of 0xFF
        trace.delete();
        tick(1'b1, 8'hFF);
        idle(1 + BIT_CLKS + 3*BIT_CLKS + BIT_CLKS/2 - 1);
        check("s5_mid_frame_busy", tx_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("s5_rst_tx", tx, 1'b1);
        check("s5_rst_busy", tx_busy, 1'b0);
        repeat (2) @(posedge sclk);
        #1;
        rst_n = 1'b1;
        model_reset();
        trace.delete();
        idle(2 * FRAME_CLKS);
        check_frames("s5_quiet");
        trace.delete();
        tick(1'b1, 8'h00);
        drain();
        check_frames("s5_after");
        if (fr_start.size() > 0) check("s5_fall_latency", fr_start[0] + 1, 2);

        // Loopback: a line-level receiver recovers each byte and strobes it back in
        lb_bytes[0] = 8'h00;
        lb_bytes[1] = 8'hFF;
        lb_bytes[2] = 8'h5A;
        for (int n = 0; n < 3; n++) begin
            trace.delete();
            bits = {1'b1, lb_bytes[n], 1'b0};
            rec  = 8'h00;
            for (int b = 0; b < 10; b++) begin
                for (int j = 0; j < BIT_CLKS; j++) begin
                    rx_line = bits[b];
                    if (j == BIT_CLKS/2 && b >= 1 && b <= 8) rec[b-1] = rx_line;
                    tick(1'b0, 8'h00);
                end
            end
            rx_line = 1'b1;
            tick(1'b1, rec);
            drain();
            check_frames($sformatf("lb%0d", n));
            if (fr_data.size() > 0) check($sformatf("lb%0d_bit_exact", n), fr_data[0], lb_bytes[n]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
